// File: rtl/cryptarch_pkg.sv
// Shared cipher-architecture types: byte type, block geometry, the
// matrix/rawstring byte mapping helper and the loader state encoding.
package cryptarch_pkg;

  typedef logic [7:0] byte_t;

  localparam int BLOCK_BYTES = 16;
  localparam int MAT_DIM     = 4;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_e;

  // Matrix element [i][j] (row i, column j) sits at this rawstring byte.
  function automatic int byte_idx(input int i, input int j);
    return MAT_DIM * j + i;
  endfunction

endpackage

// File: rtl/dematrixify.sv
// Flattens the 4x4 byte state matrix back into the 128-bit rawstring.
// Element [i][j] lands at rawstring byte 4*j+i (column-major order).
module dematrixify
  import cryptarch_pkg::*;
(
  input  logic [MAT_DIM-1:0][MAT_DIM-1:0][7:0] matrix_i,
  output logic [8*BLOCK_BYTES-1:0]             rawstring_o
);

  // Place every matrix element at its column-major byte position.
  always_comb begin
    rawstring_o = '0;
    for (int i = 0; i < MAT_DIM; i++) begin
      for (int j = 0; j < MAT_DIM; j++) begin
        rawstring_o[8*byte_idx(i, j) +: 8] = matrix_i[i][j];
      end
    end
  end

endmodule

// File: rtl/matrixify_loader.sv
// Collects a 16-byte stream (valid/ready) into the 4x4 cipher state matrix
// and offers the finished block on an output valid/ready handshake.
// Optional feature: define MATRIXIFY_LOADER_ABORT_EN to add an 'abort' input
// that discards a partial block in LOAD or drops a held block in FULL.
module matrixify_loader
  import cryptarch_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3:0][3:0][7:0]  matrix,
  output logic [127:0]          rawstring,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MATRIXIFY_LOADER_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  state_e                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [3:0][3:0][7:0]  matrix_q, matrix_d;
  logic [3:0]            idx;
  logic                  abortHit;

`ifdef MATRIXIFY_LOADER_ABORT_EN
  assign abortHit = abort;
`else
  assign abortHit = 1'b0;
`endif

  // Next-state, byte placement and handshake outputs; abort overrides all.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    matrix_d  = matrix_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    idx       = MSB_FIRST ? (4'(BLOCK_BYTES - 1) - count_q) : count_q;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int i = 0; i < MAT_DIM; i++) begin
            for (int j = 0; j < MAT_DIM; j++) begin
              if (4'(byte_idx(i, j)) == idx) begin
                matrix_d[i][j] = in_byte;
              end
            end
          end
          count_d = count_q + 4'd1;
          if (count_q == 4'(BLOCK_BYTES - 1)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    if (abortHit) begin
      matrix_d = matrix_q;
      count_d  = '0;
      state_d  = LOAD;
    end
  end

  // State, byte counter and matrix storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD;
      count_q  <= '0;
      matrix_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      matrix_q <= matrix_d;
    end
  end

  assign matrix = matrix_q;

  dematrixify u_dematrixify (
    .matrix_i    (matrix_q),
    .rawstring_o (rawstring)
  );

endmodule

// File: tb/tb_matrixify_loader.sv
// Self-checking bench for matrixify_loader: drives one MSB-first and one
// LSB-first instance from the same stream and compares both against a
// stream-level reference model. Abort tests run when
// MATRIXIFY_LOADER_ABORT_EN is defined.
module tb_matrixify_loader;

  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] in_byte;
  logic in_valid;
  logic out_ready;
`ifdef MATRIXIFY_LOADER_ABORT_EN
  logic abort;
`endif

  logic inReadyM, outValidM, inReadyL, outValidL;
  logic [3:0][3:0][7:0] matrixM, matrixL;
  logic [127:0] rawM, rawL;

  int checks = 0;
  int errors = 0;
  logic [7:0] blk [16];
  logic [127:0] expM, expL;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  matrixify_loader #(.MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(inReadyM), .matrix(matrixM), .rawstring(rawM),
    .out_valid(outValidM), .out_ready(out_ready)
`ifdef MATRIXIFY_LOADER_ABORT_EN
    , .abort(abort)
`endif
  );

  matrixify_loader #(.MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(inReadyL), .matrix(matrixL), .rawstring(rawL),
    .out_valid(outValidL), .out_ready(out_ready)
`ifdef MATRIXIFY_LOADER_ABORT_EN
    , .abort(abort)
`endif
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Handshake flags of both instances: {inReadyM,outValidM,inReadyL,outValidL}.
  function automatic logic [127:0] hs();
    return {124'b0, inReadyM, outValidM, inReadyL, outValidL};
  endfunction

  // Reference: shift the stream into a 128-bit word from the end the
  // first byte should occupy.
  function automatic logic [127:0] rawFromStream(input bit msbFirst);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (msbFirst) r = {r[119:0], blk[k]};
      else          r = {blk[k], r[127:8]};
    end
    return r;
  endfunction

  // Reference: matrix[i][j] = rawstring byte 4*j+i, packed as [i][j][7:0].
  function automatic logic [127:0] matFromRaw(input logic [127:0] r);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[(32*i + 8*j) +: 8] = r[8*(4*j + i) +: 8];
    return m;
  endfunction

  // Stream blk[] with gap mode 0 = none, 1 = 3 idles before bytes 4 and 11,
  // 2 = random idles; then check the FULL block on both instances.
  task automatic applyStimulus(input int gapMode);
    int gaps;
    for (int k = 0; k < 16; k++) begin
      gaps = 0;
      if (gapMode == 1 && (k == 4 || k == 11)) gaps = 3;
      else if (gapMode == 2 && $urandom_range(0, 3) == 0) gaps = $urandom_range(1, 2);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        checkOutput("gapHs", hs(), 128'hA);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end
      @(negedge clk);
      checkOutput("loadHs", hs(), 128'hA);
      in_valid = 1'b1;
      in_byte  = blk[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    expM = rawFromStream(1'b1);
    expL = rawFromStream(1'b0);
    checkOutput("fullHs", hs(), 128'h5);
    checkOutput("rawMsb", rawM, expM);
    checkOutput("rawLsb", rawL, expL);
    checkOutput("matMsb", matrixM, matFromRaw(expM));
    checkOutput("matLsb", matrixL, matFromRaw(expL));
  endtask

  // Hold the block for holdCycles (optionally pushing junk AA bytes), then
  // accept it with a one-cycle out_ready pulse and check LOAD resumes.
  task automatic releaseBlock(input int holdCycles, input bit junk);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput("holdHs", hs(), 128'h5);
      checkOutput("holdRawMsb", rawM, expM);
      checkOutput("holdRawLsb", rawL, expL);
      in_valid = junk;
      in_byte  = 8'hAA;
    end
    @(negedge clk);
    checkOutput("holdRawMsb", rawM, expM);
    checkOutput("holdRawLsb", rawL, expL);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("noCombReady", {126'b0, inReadyM, inReadyL}, 128'h0);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("releaseHs", hs(), 128'hA);
  endtask

  // Push the first n bytes of blk[] back-to-back, leaving in_valid low.
  task automatic partialLoad(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput("partHs", hs(), 128'hA);
      in_valid = 1'b1;
      in_byte  = blk[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Directed scenarios followed by randomized blocks.
  initial begin
    logic [127:0] orderedStream;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
`ifdef MATRIXIFY_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    checkOutput("resetHs", hs(), 128'hA);
    checkOutput("resetRaw", rawM, 128'h0);
    checkOutput("resetMat", matrixL, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ordered load with spot checks on individual matrix elements.
    orderedStream = 128'h121b1904637a127974620d1577056458;
    for (int k = 0; k < 16; k++) blk[k] = orderedStream[127 - 8*k -: 8];
    applyStimulus(0);
    checkOutput("orderedRaw", rawM, 128'h121b1904637a127974620d1577056458);
    checkOutput("m33", {120'b0, matrixM[3][3]}, 128'h12);
    checkOutput("m22", {120'b0, matrixM[2][2]}, 128'h7a);
    checkOutput("m20", {120'b0, matrixM[2][0]}, 128'h05);
    checkOutput("m13", {120'b0, matrixM[1][3]}, 128'h19);
    checkOutput("m11", {120'b0, matrixM[1][1]}, 128'h0d);
    checkOutput("m00", {120'b0, matrixM[0][0]}, 128'h58);
    releaseBlock(5, 1'b0);

    // Same stream with stalls, then backpressure with junk bytes.
    applyStimulus(1);
    checkOutput("stallRaw", rawM, 128'h121b1904637a127974620d1577056458);
    releaseBlock(4, 1'b1);
    for (int k = 0; k < 16; k++) blk[k] = 8'(k);
    applyStimulus(0);
    checkOutput("seqRaw", rawM, 128'h000102030405060708090a0b0c0d0e0f);
    releaseBlock(0, 1'b0);

    // Mid-block reset discards the partial block.
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    partialLoad(7);
    reset_n = 1'b0;
    #1;
    checkOutput("midResetHs", hs(), 128'hA);
    checkOutput("midResetRaw", rawM, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    applyStimulus(0);
    releaseBlock(1, 1'b0);

`ifdef MATRIXIFY_LOADER_ABORT_EN
    // Abort mid-block (with a competing byte), then a block of 5a.
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    partialLoad(9);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h77;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    checkOutput("abortLoadHs", hs(), 128'hA);
    for (int k = 0; k < 16; k++) blk[k] = 8'h5a;
    applyStimulus(0);
    checkOutput("abortFill", rawM, {16{8'h5a}});
    // Abort in FULL wins over a simultaneous output accept.
    abort     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    checkOutput("abortFullHs", hs(), 128'hA);
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    applyStimulus(0);
    releaseBlock(0, 1'b0);
`endif

    // Randomized blocks with random gaps, hold times and junk bytes.
    for (int b = 0; b < 25; b++) begin
      for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
      applyStimulus(2);
      releaseBlock($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
